// File: rtl/drap_ifetch_pc_unit_if.sv
// IFETCH PC-unit bus: adder operands, instruction-memory handshake, redirects and IF/ID outputs.
interface drap_ifetch_pc_unit_if #(
    parameter int unsigned B = 32
);
    logic [B-1:0] pc_out;
    logic [B-1:0] inc_out;
    logic [B-1:0] adder_sum;
    logic         imem_req;
    logic         imem_ready;
    logic [B-1:0] imem_rdata;
    logic         br_taken;
    logic [B-1:0] br_target;
    logic         jmp_taken;
    logic [B-1:0] jmp_target;
    logic         exc_req;
    logic         id_stall;
    logic         id_valid;
    logic [B-1:0] id_instr;
    logic [B-1:0] id_pc_plus4;

    modport master (
        output pc_out, inc_out, imem_req, id_valid, id_instr, id_pc_plus4,
        input  adder_sum, imem_ready, imem_rdata, br_taken, br_target,
               jmp_taken, jmp_target, exc_req, id_stall
    );

    modport slave (
        input  pc_out, inc_out, imem_req, id_valid, id_instr, id_pc_plus4,
        output adder_sum, imem_ready, imem_rdata, br_taken, br_target,
               jmp_taken, jmp_target, exc_req, id_stall
    );
endinterface

// File: rtl/drap_ifetch_pc_unit.sv
// IFETCH program-counter / next-PC stage with imem handshake and IF/ID register.
// Optional macro DRAP_IFETCH_MISALIGN_TRAP_EN: misaligned jump/branch targets trap to EXC_VEC.
module drap_ifetch_pc_unit #(
    parameter int unsigned B        = 32,
    parameter logic [B-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [B-1:0] EXC_VEC  = 32'h0000_0180,
    parameter int unsigned INC      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    drap_ifetch_pc_unit_if.master       bus
`ifdef DRAP_IFETCH_MISALIGN_TRAP_EN
    ,
    output logic                        misalign_fault
`endif
);

    typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

    localparam logic [B-1:0] AlignMask = ~B'(3);

    state_e       state_q, state_d;
    logic [B-1:0] pc_q, pc_d;
    logic [B-1:0] hold_instr_q, hold_instr_d;
    logic [B-1:0] hold_sum_q, hold_sum_d;
    logic         id_valid_q, id_valid_d;
    logic [B-1:0] id_instr_q, id_instr_d;
    logic [B-1:0] id_pc_plus4_q, id_pc_plus4_d;

    logic         redirect;
    logic [B-1:0] raw_target;
    logic [B-1:0] redirect_pc;

    assign redirect   = bus.exc_req | bus.jmp_taken | bus.br_taken;
    assign raw_target = bus.jmp_taken ? bus.jmp_target : bus.br_target;

`ifdef DRAP_IFETCH_MISALIGN_TRAP_EN
    logic misalign;
    logic fault_q;

    // Exception outranks the misalignment check, so a trap never masks exc_req.
    assign misalign    = !bus.exc_req && (bus.jmp_taken || bus.br_taken) &&
                         (raw_target[1:0] != 2'b00);
    assign redirect_pc = (bus.exc_req || misalign) ? EXC_VEC : raw_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= misalign;
        end
    end

    assign misalign_fault = fault_q;
`else
    assign redirect_pc = bus.exc_req ? EXC_VEC : (raw_target & AlignMask);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StBoot:  state_d = StFetch;
                StFetch: if (bus.imem_ready && bus.id_stall) state_d = StHold;
                StHold:  if (!bus.id_stall) state_d = StFetch;
                default: state_d = StBoot;
            endcase
        end
    end

    always_comb begin
        pc_d          = pc_q;
        hold_instr_d  = hold_instr_q;
        hold_sum_d    = hold_sum_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        if (redirect) begin
            // Flush: any rdata returned this cycle belongs to the abandoned path.
            pc_d         = redirect_pc;
            id_valid_d   = 1'b0;
            hold_instr_d = '0;
            hold_sum_d   = '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (bus.imem_ready && !bus.id_stall) begin
                        id_valid_d    = 1'b1;
                        id_instr_d    = bus.imem_rdata;
                        id_pc_plus4_d = bus.adder_sum;
                        pc_d          = bus.adder_sum;
                    end else if (bus.imem_ready) begin
                        hold_instr_d = bus.imem_rdata;
                        hold_sum_d   = bus.adder_sum;
                    end else if (!bus.id_stall) begin
                        id_valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (!bus.id_stall) begin
                        id_valid_d    = 1'b1;
                        id_instr_d    = hold_instr_q;
                        id_pc_plus4_d = hold_sum_q;
                        pc_d          = hold_sum_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            hold_instr_q  <= '0;
            hold_sum_q    <= '0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_plus4_q <= '0;
        end else begin
            pc_q          <= pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_sum_q    <= hold_sum_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.inc_out     = B'(INC);
    assign bus.imem_req    = (state_q == StFetch);
    assign bus.id_valid    = id_valid_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;

endmodule

// File: tb/tb_drap_ifetch_pc_unit.sv
// Randomized scoreboard bench for drap_ifetch_pc_unit against a transaction-level PC/fetch model.
module tb_drap_ifetch_pc_unit;

    localparam int unsigned B   = 32;
    localparam logic [31:0] EXC = 32'h0000_0180;

    typedef struct packed {
        logic        r;
        logic        rdy;
        logic [31:0] rdata;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        exc;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        req;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] plus4;
        logic        fault;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    drap_ifetch_pc_unit_if #(.B(B)) bus ();

`ifdef DRAP_IFETCH_MISALIGN_TRAP_EN
    logic misalign_fault;
`endif

    drap_ifetch_pc_unit #(
        .B        (B),
        .RESET_PC (32'h0000_0000),
        .EXC_VEC  (EXC),
        .INC      (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.master)
`ifdef DRAP_IFETCH_MISALIGN_TRAP_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    // The external IFETCH adder.
    assign bus.adder_sum = bus.pc_out + bus.inc_out;

    always #5 clk = ~clk;

    snap_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model: architectural PC, IF/ID contents, and fetched-but-undelivered words.
    logic [31:0] m_pc, m_instr, m_plus4;
    logic        m_valid, m_boot, m_fault;
    logic [63:0] m_pending[$];

    function automatic void model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_plus4 = 32'h0;
        m_valid = 1'b0;
        m_boot  = 1'b1;
        m_fault = 1'b0;
        m_pending.delete();
    endfunction

    function automatic void model_next(input stim_t s);
        logic [31:0] seq;
        logic [31:0] raw;
        seq     = m_pc + 32'd4;
        raw     = s.jmp ? s.jt : s.bt;
        m_fault = 1'b0;
        if (s.exc || s.jmp || s.br) begin
            if (s.exc) begin
                m_pc = EXC;
            end else begin
`ifdef DRAP_IFETCH_MISALIGN_TRAP_EN
                if (raw[1:0] != 2'b00) begin
                    m_pc    = EXC;
                    m_fault = 1'b1;
                end else begin
                    m_pc = raw;
                end
`else
                m_pc = {raw[31:2], 2'b00};
`endif
            end
            m_valid = 1'b0;
            m_boot  = 1'b0;
            m_pending.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_pending.size() != 0) begin
            if (!s.stall) begin
                {m_instr, m_plus4} = m_pending.pop_front();
                m_valid            = 1'b1;
                m_pc               = m_plus4;
            end
        end else if (s.rdy) begin
            if (!s.stall) begin
                m_instr = s.rdata;
                m_plus4 = seq;
                m_valid = 1'b1;
                m_pc    = seq;
            end else begin
                m_pending.push_back({s.rdata, seq});
            end
        end else if (!s.stall) begin
            m_valid = 1'b0;
        end
    endfunction

    function automatic void push_exp();
        snap_t e;
        e.pc    = m_pc;
        e.req   = !m_boot && (m_pending.size() == 0);
        e.valid = m_valid;
        e.instr = m_instr;
        e.plus4 = m_plus4;
        e.fault = m_fault;
        exp_q.push_back(e);
    endfunction

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        rst = s.r;
        if (s.r) model_reset();
        push_exp();
        bus.imem_ready = s.rdy;
        bus.imem_rdata = s.rdata;
        bus.id_stall   = s.stall;
        bus.br_taken   = s.br;
        bus.br_target  = s.bt;
        bus.jmp_taken  = s.jmp;
        bus.jmp_target = s.jt;
        bus.exc_req    = s.exc;
        if (!s.r) model_next(s);
    endtask

    task automatic fetch(input logic rdy, input logic [31:0] rdata, input logic stall);
        stim_t s = '0;
        s.rdy   = rdy;
        s.rdata = rdata;
        s.stall = stall;
        step(s);
    endtask

    task automatic redir(input logic br, input logic [31:0] bt, input logic jmp,
                         input logic [31:0] jt, input logic exc);
        stim_t s = '0;
        s.rdy   = 1'b1;
        s.rdata = 32'hDEAD_BEEF;
        s.br    = br;
        s.bt    = bt;
        s.jmp   = jmp;
        s.jt    = jt;
        s.exc   = exc;
        step(s);
    endtask

    task automatic hold_reset(input int n);
        stim_t s = '0;
        s.r = 1'b1;
        repeat (n) step(s);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t = $urandom;
        if ($urandom_range(9) < 8) t[1:0] = 2'b00;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected snapshot per cycle, compared mid-cycle.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc_out",      bus.pc_out,             e.pc);
                check("inc_out",     bus.inc_out,            32'd4);
                check("imem_req",    {31'b0, bus.imem_req},  {31'b0, e.req});
                check("id_valid",    {31'b0, bus.id_valid},  {31'b0, e.valid});
                check("id_instr",    bus.id_instr,           e.instr);
                check("id_pc_plus4", bus.id_pc_plus4,        e.plus4);
`ifdef DRAP_IFETCH_MISALIGN_TRAP_EN
                check("misalign_fault", {31'b0, misalign_fault}, {31'b0, e.fault});
`endif
            end
        end
    end

    initial begin
        stim_t s;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        bus.id_stall   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = '0;
        bus.jmp_taken  = 1'b0;
        bus.jmp_target = '0;
        bus.exc_req    = 1'b0;
        model_reset();

        hold_reset(3);
        fetch(1'b0, 32'h0, 1'b0);              // release: boot cycle
        fetch(1'b1, 32'hA0, 1'b0);             // pc 0
        fetch(1'b1, 32'hA1, 1'b0);             // pc 4
        fetch(1'b1, 32'hA2, 1'b1);             // pc 8, stalled -> hold
        fetch(1'b1, 32'h55, 1'b1);
        fetch(1'b0, 32'h66, 1'b1);
        fetch(1'b0, 32'h0, 1'b0);              // release hold
        fetch(1'b1, 32'hA3, 1'b0);             // pc 0xC
        redir(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        fetch(1'b0, 32'h0, 1'b0);
        redir(1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
        fetch(1'b0, 32'h0, 1'b0);
        redir(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        fetch(1'b1, 32'hC0DE, 1'b0);           // wrap to 0
        fetch(1'b0, 32'h0, 1'b0);
        redir(1'b1, 32'h102, 1'b0, 32'h0, 1'b0);
        fetch(1'b0, 32'h0, 1'b0);
        fetch(1'b1, 32'hB0, 1'b0);
        redir(1'b0, 32'h0, 1'b1, 32'h301, 1'b0);
        fetch(1'b0, 32'h0, 1'b0);
        fetch(1'b1, 32'hB1, 1'b1);             // hold, then redirect while stalled
        redir(1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
        fetch(1'b1, 32'hB2, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 399) begin
                // Reset in the middle of traffic.
                hold_reset(2);
            end else begin
                s       = '0;
                s.rdy   = ($urandom_range(9) < 7);
                s.rdata = $urandom;
                s.stall = ($urandom_range(3) == 0);
                s.br    = ($urandom_range(99) < 8);
                s.bt    = rand_target();
                s.jmp   = ($urandom_range(99) < 5);
                s.jt    = rand_target();
                s.exc   = ($urandom_range(99) < 3);
                step(s);
            end
        end

        fetch(1'b0, 32'h0, 1'b0);
        fetch(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/drap_ifetch_pc_unit.md
Name: drap_ifetch_pc_unit

Overview:
- Program-counter and next-PC stage of the IFETCH module.
- Holds the PC and drives it, with constant INC, into the IFETCH adder.
- Consumes the adder sum as PC+INC and selects next PC among sequential, branch, jump and exception vector.
- Runs the instruction-memory request handshake and the IF/ID pipeline register, with stall and flush.

Parameters:
B, 32, data/address bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VEC, 32'h0000_0180, exception redirect target
INC, 4, sequential increment driven to adder op2

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
pc_out  output  B  current PC; to adder op1 and imem address
inc_out  output  B  constant INC; to adder op2
adder_sum  input  B  adder result (pc_out + INC)
imem_req  output  1  fetch request
imem_ready  input  1  imem_rdata valid this cycle
imem_rdata  input  B  fetched instruction
br_taken  input  1  branch redirect
br_target  input  B  branch target
jmp_taken  input  1  jump redirect
jmp_target  input  B  jump target
exc_req  input  1  exception redirect
id_stall  input  1  decode cannot accept
id_valid  output  1  IF/ID entry valid
id_instr  output  B  IF/ID instruction
id_pc_plus4  output  B  IF/ID sequential PC (adder_sum at fetch)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: pc_out=RESET_PC, state=S_BOOT, imem_req=0, id_valid=0, id_instr=0, id_pc_plus4=0, hold buffer cleared. inc_out is constant INC.
- Reset mid-fetch: any in-flight fetch is abandoned and all state returns to reset values.
- Next PC priority: exc_req > jmp_taken > br_taken > sequential (adder_sum).
- Arithmetic wraps modulo 2^B; adder_sum 0xFFFFFFFC+4 gives 0x00000000.
- States:
  - S_BOOT: imem_req=0. Next cycle, unconditionally, go to S_FETCH.
  - S_FETCH: imem_req=1, address=pc_out. pc_out stays stable while imem_ready=0.
    - imem_ready=1 and id_stall=0: on the next edge, id_valid<=1, id_instr<=imem_rdata, id_pc_plus4<=adder_sum, pc_out<=adder_sum. Stay in S_FETCH.
    - imem_ready=1 and id_stall=1: capture imem_rdata and adder_sum in the hold buffer, then go to S_HOLD. IF/ID register unchanged.
    - imem_ready=0 and id_stall=0: id_valid<=0 (bubble).
    - id_stall=1: IF/ID register holds its value in every state.
  - S_HOLD: imem_req=0; pc_out unchanged. When id_stall=0, move the hold buffer into IF/ID (id_valid<=1), set pc_out<=buffered sum, go to S_FETCH.
- Latency: an instruction appears on id_* one cycle after the edge where imem_ready=1 (or after stall release in S_HOLD).
- Redirect (any of exc_req, jmp_taken, br_taken):
  - Takes effect at the next edge in any state, regardless of id_stall.
  - pc_out<=selected target; id_valid<=0 (flush); hold buffer discarded; state<=S_FETCH.
  - imem_rdata arriving in the same cycle is dropped.
  - imem may see the request address change while pending; that is permitted abandonment.
- Redirect in S_BOOT: honoured; the PC is loaded and S_FETCH follows.

Optional Feature:
- Macro DRAP_IFETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_fault (1 bit, reset 0).
  - A selected jmp/br target with bits[1:0]!=0 redirects to EXC_VEC instead, flushes, and pulses misalign_fault high for one cycle.
  - exc_req still has highest priority.
- Undefined: port absent; target bits[1:0] are forced to 0 when loaded into the PC.

Test Plan:
- Reset held 3 cycles, then released -> pc_out=0x0, imem_req=0 for one cycle, then 1; id_valid=0 throughout.
- imem_ready always 1, no stall, rdata=0xA0,0xA1,0xA2 -> pc_out 0,4,8,0xC; id_instr 0xA0,0xA1,0xA2 with id_pc_plus4 4,8,0xC, one cycle behind.
- id_stall=1 while imem_ready=1 at pc 0x8 -> S_HOLD, imem_req=0, pc_out=0x8 held; release -> id_instr=held rdata, id_pc_plus4=0xC, pc_out=0xC.
- br_taken(0x100) and jmp_taken(0x200) together -> pc_out=0x200, id_valid=0 next cycle; adding exc_req -> pc_out=0x180.
- Jump to 0xFFFFFFFC, imem_ready=1 -> id_pc_plus4=0x0, pc_out=0x0.
- br_target=0x102: with macro -> pc_out=0x180 and misalign_fault one-cycle pulse; without macro -> pc_out=0x100.
